multicycle_cpu: RTL

Parametrised multi-cycle successor to the single-cycle 16-bit mini-MIPS core. It executes the same 16-bit instruction formats:
- R-type: opcode[15:12] | rs[11:10] | rt[9:8] | rd[7:6] | unused[5:0]
- I-type: opcode[15:12] | rs[11:10] | rd/rt[9:8] | imm8[7:0]

The datapath width is configurable. Instruction and data accesses share one memory port with a req/ready handshake, so the memory may insert wait states. Adds sub/and/or, a HALT instruction and asynchronous reset.

---
 rtl/multicycle_cpu_if.sv | 23 ++
 rtl/multicycle_cpu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu_if.sv
// Shared instruction/data memory port of the multi-cycle core.
// One request at a time; an access completes on any edge with mem_req and mem_ready both high.
interface multicycle_cpu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-instruction mini-MIPS core, configurable datapath width,
// single shared memory port with req/ready wait states.
//
// state  | meaning
// FETCH  | read instruction at pc, pc += 2 on completion
// DECODE | latch A/B from register file, classify opcode
// EXEC   | ALU op, load/store address, or branch resolve
// MEM    | data load/store through the shared port
// WB     | register file write
// HALT   | frozen until reset
module multicycle_cpu #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  multicycle_cpu_if.master  bus,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic [DATA_W-1:0] alu_out,
  output logic              halted
);

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rf [4];
  logic [DATA_W-1:0] reg_a, reg_b, mdr, alu_res, imm_sext;
  logic [ADDR_W-1:0] br_off;
  logic [3:0]        opc;
  logic [1:0]        rs, rt, rd, wr_sel;
  logic              is_rtype, is_nop, is_branch, br_taken;

  assign opc       = ir[15:12];
  assign rs        = ir[11:10];
  assign rt        = ir[9:8];
  assign rd        = ir[7:6];
  assign imm_sext  = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign br_off    = {{(ADDR_W-9){ir[7]}}, ir[7:0], 1'b0};
  assign is_rtype  = (opc <= OP_SLT) && (opc != 4'h5);
  assign is_nop    = opc inside {4'h5, 4'hC, 4'hD, 4'hE};
  assign is_branch = (opc == OP_BEQ) || (opc == OP_BNE);
  assign br_taken  = (opc == OP_BEQ) ? (reg_a == reg_b) : (reg_a != reg_b);
  assign wr_sel    = is_rtype ? rd : rt;
  assign halted    = (state == ST_HALT);

  always_comb begin
    alu_res = '0;
    case (opc)
      OP_ADD:                 alu_res = reg_a + reg_b;
      OP_SUB:                 alu_res = reg_a - reg_b;
      OP_AND:                 alu_res = reg_a & reg_b;
      OP_OR:                  alu_res = reg_a | reg_b;
      OP_NOR:                 alu_res = ~(reg_a | reg_b);
      OP_SLT:                 alu_res = {{(DATA_W-1){1'b0}}, $signed(reg_a) < $signed(reg_b)};
      OP_ADDI, OP_LW, OP_SW:  alu_res = reg_a + imm_sext;
      default:                alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      ST_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = pc;
        if (bus.mem_ready) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (opc == OP_HALT) state_nxt = ST_HALT;
        else if (is_nop)    state_nxt = ST_FETCH;
        else                state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_rtype || opc == OP_ADDI)      state_nxt = ST_WB;
        else if (opc == OP_LW || opc == OP_SW) state_nxt = ST_MEM;
        else                                 state_nxt = ST_FETCH;
      end
      ST_MEM: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = alu_out[ADDR_W-1:0];
        if (opc == OP_SW) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = reg_b;
        end
        if (bus.mem_ready) state_nxt = (opc == OP_SW) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
    // Reset must silence the port immediately, not on the next edge.
    if (reset) begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      alu_out <= '0;
      reg_a   <= '0;
      reg_b   <= '0;
      mdr     <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            ir <= bus.mem_rdata[15:0];
            pc <= pc + ADDR_W'(2);
          end
        end
        ST_DECODE: begin
          reg_a <= rf[rs];
          reg_b <= rf[rt];
        end
        ST_EXEC: begin
          // Branch offset is relative to the already-incremented pc.
          if (is_branch) begin
            if (br_taken) pc <= pc + br_off;
          end else begin
            alu_out <= alu_res;
          end
        end
        ST_MEM: begin
          if (bus.mem_ready && opc == OP_LW) mdr <= bus.mem_rdata;
        end
        ST_WB: begin
          if (wr_sel != 2'd0) rf[wr_sel] <= (opc == OP_LW) ? mdr : alu_out;
        end
        default: ;
      endcase
    end
  end

endmodule
